// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_pkg
//  Brief    : Shared constants and helpers for the A/D pre-adder front end.
//  Revision : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    localparam int IM_A1_SEL = 0;
    localparam int IM_A_ZERO = 1;
    localparam int IM_D_EN   = 2;
    localparam int IM_SUB    = 3;

    function automatic longint sat_max(input int m_width);
        return (longint'(1) <<< (m_width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int m_width);
        return -(longint'(1) <<< (m_width - 1));
    endfunction

    // Edges from in_valid to out_valid, measured with the A tap on AMUX
    function automatic int preadd_latency(input int a_depth, input int ad_depth, input int use_dport);
        return a_depth + ((use_dport != 0) ? ad_depth : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line_ce.sv
`default_nettype none
// ============================================================================
//  Module   : delay_line_ce
//  Brief    : Clock-enabled shift register with sync reset; DEPTH 0 is a wire.
//  Revision : 1.0 - initial release
// ============================================================================
module delay_line_ce #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [WIDTH-1:0] o_stage0
);

    if (DEPTH == 0) begin : g_wire
        logic w_ctrl_unused;
        assign w_ctrl_unused = ^{clk, rst, ce};
        assign o_dout   = i_din;
        assign o_stage0 = i_din;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= '0;
                end
            end else if (ce) begin
                r_stage[0] <= i_din;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_dout   = r_stage[DEPTH-1];
        assign o_stage0 = r_stage[0];
    end

endmodule
`default_nettype wire

// File: rtl/preadd_pipe_gen.sv
`default_nettype none
// ============================================================================
//  Module   : preadd_pipe_gen
//  Brief    : A/D operand front end with pre-adder and valid-token tracking.
//             Optional macro PREADD_SAT_EN: saturating pre-adder + preadd_ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module preadd_pipe_gen
    import dsp_pkg::*;
#(
    parameter int A_WIDTH    = 30,
    parameter int M_WIDTH    = 25,
    parameter int A_DEPTH    = 2,
    parameter int D_DEPTH    = 1,
    parameter int AD_DEPTH   = 1,
    parameter int USE_DPORT  = 1,
    parameter int INMODE_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               a_input_sel,
    input  logic [A_WIDTH-1:0] A,
    input  logic [A_WIDTH-1:0] ACIN,
    input  logic [M_WIDTH-1:0] D,
    input  logic [3:0]         IN_MODE,
    input  logic               in_valid,
    output logic [A_WIDTH-1:0] AMUX,
    output logic [A_WIDTH-1:0] ACOUT,
    output logic [M_WIDTH-1:0] A_MULT,
    output logic               out_valid
`ifdef PREADD_SAT_EN
    ,
    output logic               preadd_ovf
`endif
);

    localparam int c_LAT = preadd_latency(A_DEPTH, AD_DEPTH, USE_DPORT);

    logic [3:0]         w_im;
    logic [A_WIDTH-1:0] w_a_sel;
    logic [A_WIDTH-1:0] w_amux;
    logic [A_WIDTH-1:0] w_a_stage0;
    logic [A_WIDTH-1:0] w_tap;
    logic [M_WIDTH-1:0] w_a_pre;
    logic               w_v_stage0_unused;

    if (INMODE_REG != 0) begin : g_im_reg
        logic [3:0] r_im;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_im <= '0;
            end else if (ce) begin
                r_im <= IN_MODE;
            end
        end
        assign w_im = r_im;
    end else begin : g_im_comb
        assign w_im = IN_MODE;
    end

    assign w_a_sel = a_input_sel ? A : ACIN;

    delay_line_ce #(
        .WIDTH (A_WIDTH),
        .DEPTH (A_DEPTH)
    ) u_a_pipe (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .i_din    (w_a_sel),
        .o_dout   (w_amux),
        .o_stage0 (w_a_stage0)
    );

    assign AMUX  = w_amux;
    assign ACOUT = w_amux;

    // Early tap only exists when there is a distinct first stage to pick
    if (A_DEPTH >= 2) begin : g_tap_sel
        assign w_tap = w_im[IM_A1_SEL] ? w_a_stage0 : w_amux;
    end else begin : g_tap_amux
        logic w_tap_unused;
        assign w_tap_unused = ^{w_im[IM_A1_SEL], w_a_stage0};
        assign w_tap = w_amux;
    end

    if (A_WIDTH > M_WIDTH) begin : g_tap_trunc
        logic w_tap_hi_unused;
        assign w_tap_hi_unused = ^w_tap[A_WIDTH-1:M_WIDTH];
    end

    assign w_a_pre = w_im[IM_A_ZERO] ? '0 : w_tap[M_WIDTH-1:0];

    if (USE_DPORT != 0) begin : g_dport
        logic [M_WIDTH-1:0] w_d_last;
        logic [M_WIDTH-1:0] w_d_stage0_unused;
        logic [M_WIDTH-1:0] w_d_pre;
        logic [M_WIDTH-1:0] w_sum;

        delay_line_ce #(
            .WIDTH (M_WIDTH),
            .DEPTH (D_DEPTH)
        ) u_d_pipe (
            .clk      (clk),
            .rst      (rst),
            .ce       (ce),
            .i_din    (D),
            .o_dout   (w_d_last),
            .o_stage0 (w_d_stage0_unused)
        );

        assign w_d_pre = w_im[IM_D_EN] ? w_d_last : '0;

`ifdef PREADD_SAT_EN
        localparam logic [M_WIDTH-1:0] c_SAT_MAX = M_WIDTH'(sat_max(M_WIDTH));
        localparam logic [M_WIDTH-1:0] c_SAT_MIN = M_WIDTH'(sat_min(M_WIDTH));
        logic [M_WIDTH:0] w_sum_wide;
        logic             w_ovf;

        assign w_sum_wide = w_im[IM_SUB]
                          ? ({w_d_pre[M_WIDTH-1], w_d_pre} - {w_a_pre[M_WIDTH-1], w_a_pre})
                          : ({w_d_pre[M_WIDTH-1], w_d_pre} + {w_a_pre[M_WIDTH-1], w_a_pre});
        // Top two bits disagree exactly when the true result left the M_WIDTH range
        assign w_ovf = w_sum_wide[M_WIDTH] ^ w_sum_wide[M_WIDTH-1];
        assign w_sum = !w_ovf ? w_sum_wide[M_WIDTH-1:0]
                     : (w_sum_wide[M_WIDTH] ? c_SAT_MIN : c_SAT_MAX);
`else
        assign w_sum = w_im[IM_SUB] ? (w_d_pre - w_a_pre) : (w_d_pre + w_a_pre);
`endif

        if (AD_DEPTH != 0) begin : g_ad_reg
            logic [M_WIDTH-1:0] r_ad;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ad <= '0;
                end else if (ce) begin
                    r_ad <= w_sum;
                end
            end
            assign A_MULT = r_ad;
`ifdef PREADD_SAT_EN
            logic r_ovf;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (ce) begin
                    r_ovf <= w_ovf;
                end
            end
            assign preadd_ovf = r_ovf;
`endif
        end else begin : g_ad_comb
            assign A_MULT = w_sum;
`ifdef PREADD_SAT_EN
            assign preadd_ovf = w_ovf;
`endif
        end
    end else begin : g_no_dport
        logic w_dport_unused;
        assign w_dport_unused = ^{D, w_im[IM_D_EN], w_im[IM_SUB]};
        assign A_MULT = w_a_pre;
`ifdef PREADD_SAT_EN
        assign preadd_ovf = 1'b0;
`endif
    end

    delay_line_ce #(
        .WIDTH (1),
        .DEPTH (c_LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .i_din    (in_valid),
        .o_dout   (out_valid),
        .o_stage0 (w_v_stage0_unused)
    );

endmodule
`default_nettype wire

// File: tb/tb_preadd_pipe_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preadd_pipe_gen
//  Brief    : Self-checking bench for preadd_pipe_gen with a history-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_preadd_pipe_gen;

    localparam int AW = 30;
    localparam int MW = 25;
    localparam int A_DEPTH = 2;
    localparam int D_DEPTH = 1;
    localparam int AD_DEPTH = 1;
    localparam int USE_DPORT = 1;
    localparam int INMODE_REG = 1;
    localparam int L = A_DEPTH + ((USE_DPORT != 0) ? AD_DEPTH : 0);
    localparam int HN = 4096;
    localparam longint MAXV = (longint'(1) <<< (MW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (MW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic a_input_sel = 1'b0;
    logic [AW-1:0] A = '0;
    logic [AW-1:0] ACIN = '0;
    logic [MW-1:0] D = '0;
    logic [3:0] IN_MODE = '0;
    logic in_valid = 1'b0;
    logic [AW-1:0] AMUX, ACOUT;
    logic [MW-1:0] A_MULT;
    logic out_valid;
`ifdef PREADD_SAT_EN
    logic preadd_ovf;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    preadd_pipe_gen #(
        .A_WIDTH(AW), .M_WIDTH(MW), .A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH),
        .AD_DEPTH(AD_DEPTH), .USE_DPORT(USE_DPORT), .INMODE_REG(INMODE_REG)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .a_input_sel(a_input_sel),
        .A(A), .ACIN(ACIN), .D(D), .IN_MODE(IN_MODE), .in_valid(in_valid),
        .AMUX(AMUX), .ACOUT(ACOUT), .A_MULT(A_MULT), .out_valid(out_valid)
`ifdef PREADD_SAT_EN
        , .preadd_ovf(preadd_ovf)
`endif
    );

    // Histories of inputs captured at each ce-qualified edge since the last reset
    logic [AW-1:0] a_h [HN];
    logic [MW-1:0] d_h [HN];
    logic [3:0]    im_h [HN];
    logic          v_h [HN];
    int n = 0;

    always @(posedge clk) begin
        if (rst) begin
            n <= 0;
        end else if (ce) begin
            n <= n + 1;
            a_h[(n + 1) % HN]  <= a_input_sel ? A : ACIN;
            d_h[(n + 1) % HN]  <= D;
            im_h[(n + 1) % HN] <= IN_MODE;
            v_h[(n + 1) % HN]  <= in_valid;
        end
    end

    function automatic logic [AW-1:0] ha(input int i);
        return (i >= 1) ? a_h[i % HN] : '0;
    endfunction
    function automatic logic [MW-1:0] hd(input int i);
        return (i >= 1) ? d_h[i % HN] : '0;
    endfunction
    function automatic logic [3:0] him(input int i);
        return (i >= 1) ? im_h[i % HN] : '0;
    endfunction
    function automatic logic hv(input int i);
        return (i >= 1) ? v_h[i % HN] : 1'b0;
    endfunction

    function automatic logic [AW-1:0] m_amux(input int m, input logic [AW-1:0] ca);
        return (A_DEPTH == 0) ? ca : ha(m - A_DEPTH + 1);
    endfunction

    function automatic logic [MW-1:0] m_apre(input int m, input logic [AW-1:0] ca, input logic [3:0] im);
        logic [AW-1:0] tap;
        tap = (im[0] && A_DEPTH >= 2) ? ha(m) : m_amux(m, ca);
        return im[1] ? '0 : tap[MW-1:0];
    endfunction

    // Pre-adder result for the state after edge m, given the inputs currently applied
    function automatic logic [MW-1:0] m_sum(input int m, input logic [AW-1:0] ca,
                                            input logic [MW-1:0] cd, input logic [3:0] cim,
                                            output logic ovf);
        logic [3:0] im;
        logic [MW-1:0] ap, dp;
        longint av, dv, s, r;
        im = (INMODE_REG != 0) ? him(m) : cim;
        ap = m_apre(m, ca, im);
        dp = im[2] ? ((D_DEPTH == 0) ? cd : hd(m - D_DEPTH + 1)) : '0;
        av = $signed(ap);
        dv = $signed(dp);
        s = im[3] ? (dv - av) : (dv + av);
        ovf = (s > MAXV) || (s < MINV);
`ifdef PREADD_SAT_EN
        r = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
`else
        r = s;
`endif
        return r[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] m_amult(input int m, input logic [AW-1:0] ca,
                                              input logic [MW-1:0] cd, input logic [3:0] cim,
                                              output logic ovf);
        ovf = 1'b0;
        if (USE_DPORT == 0) return m_apre(m, ca, (INMODE_REG != 0) ? him(m) : cim);
        if (AD_DEPTH == 0) return m_sum(m, ca, cd, cim, ovf);
        if (m == 0) return '0;
        return m_sum(m - 1, ha(m), hd(m), him(m), ovf);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic ov;
        logic [MW-1:0] em;
        logic [AW-1:0] ea;
        logic ev;
        if (chk_en) begin
            em = m_amult(n, a_input_sel ? A : ACIN, D, IN_MODE, ov);
            ea = m_amux(n, a_input_sel ? A : ACIN);
            ev = (L == 0) ? in_valid : hv(n - L + 1);
            check("model_amux", 64'(AMUX), 64'(ea));
            check("model_acout", 64'(ACOUT), 64'(ea));
            check("model_a_mult", 64'(A_MULT), 64'(em));
            check("model_out_valid", 64'(out_valid), 64'(ev));
`ifdef PREADD_SAT_EN
            check("model_ovf", 64'(preadd_ovf), 64'(ov));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stall scenario: ce pattern, valid pattern and A value per cycle
    localparam int NS = 20;
    bit         st_ce [NS] = '{1,1,1,0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1};
    bit         st_v  [NS] = '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0};
    int         st_a  [NS] = '{100,101,102,200,200,200,200,103,104,0,0,0,0,0,0,0,0,0,0,0};

    initial begin
        int exp_q[$];
        int got;
        int r;
        logic ov;

        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_amux", 64'(AMUX), 64'd0);
        check("reset_a_mult", 64'(A_MULT), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);

        // Basic add with a single token
        rst = 1'b0; ce = 1'b1; a_input_sel = 1'b1;
        A = 30'd5; D = 25'd7; IN_MODE = 4'b0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_valid_e1", 64'(out_valid), 64'd0);
        tick();
        check("t1_amux_e2", 64'(AMUX), 64'd5);
        check("t1_valid_e2", 64'(out_valid), 64'd0);
        tick();
        check("t1_a_mult_e3", 64'(A_MULT), 64'd12);
        check("t1_valid_e3", 64'(out_valid), 64'd1);
        tick();
        check("t1_valid_e4", 64'(out_valid), 64'd0);

        // Subtract, then zeroed A
        IN_MODE = 4'b1100; D = 25'd3; A = 30'd10;
        repeat (3) tick();
        check("t2_sub", 64'(A_MULT), 64'h1FFFFF9);
        IN_MODE = 4'b0110;
        repeat (3) tick();
        check("t2_zero_a", 64'(A_MULT), 64'd3);

        // Cascade input, all ones
        a_input_sel = 1'b0; ACIN = 30'h3FFFFFFF; A = '0; IN_MODE = 4'b0000;
        repeat (2) tick();
        check("t3_amux", 64'(AMUX), 64'h3FFFFFFF);
        check("t3_acout", 64'(ACOUT), 64'h3FFFFFFF);
        tick();
        check("t3_a_mult", 64'(A_MULT), 64'h1FFFFFF);

        // Pre-adder range edge
        a_input_sel = 1'b1; A = 30'd1; D = 25'hFFFFFF; IN_MODE = 4'b0100;
        repeat (3) tick();
`ifdef PREADD_SAT_EN
        check("t6_sat", 64'(A_MULT), 64'hFFFFFF);
        check("t6_ovf", 64'(preadd_ovf), 64'd1);
`else
        check("t6_wrap", 64'(A_MULT), 64'h1000000);
`endif

        // Stall with tokens in flight; tokens must emerge once each, in order
        a_input_sel = 1'b1; D = '0; IN_MODE = 4'b0000; in_valid = 1'b0;
        repeat (4) tick();
        exp_q = '{100, 101, 102, 103, 104};
        got = 0;
        for (int i = 0; i < NS; i++) begin
            ce = st_ce[i]; in_valid = st_v[i]; A = AW'(st_a[i]);
            tick();
            if (st_ce[i] && out_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    check("t4_extra_token", 64'(A_MULT), 64'hFFFF_FFFF);
                end else begin
                    check("t4_token_order", 64'(A_MULT), 64'(exp_q.pop_front()));
                end
            end
        end
        check("t4_token_count", 64'(got), 64'd5);

        // Reset with tokens in flight, then a cascade token
        ce = 1'b1; a_input_sel = 1'b1; A = 30'd7; in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_a_mult", 64'(A_MULT), 64'd0);
        check("t5_rst_amux", 64'(AMUX), 64'd0);
        rst = 1'b0; a_input_sel = 1'b0; ACIN = 30'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_valid_e1", 64'(out_valid), 64'd0);
        tick();
        check("t5_valid_e2", 64'(out_valid), 64'd0);
        tick();
        check("t5_valid_e3", 64'(out_valid), 64'd1);
        check("t5_a_mult_e3", 64'(A_MULT), 64'd9);

        // Randomised traffic against the model
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ce = ($urandom_range(0, 9) < 8);
            a_input_sel = 1'($urandom);
            A = AW'($urandom);
            ACIN = AW'($urandom);
            r = $urandom_range(0, 3);
            D = (r == 0) ? 25'hFFFFFF : ((r == 1) ? 25'h1000000 : MW'($urandom));
            if ($urandom_range(0, 3) == 0) A = (r == 0) ? AW'(1) : AW'(-1);
            IN_MODE = 4'($urandom);
            in_valid = 1'($urandom);
            tick();
        end
        ov = 1'b0;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/preadd_pipe_gen.md
Name: preadd_pipe_gen

Overview:
- Parametrised A/D input stage with pre-adder, the next generation of the team's DSP-slice operand front end.
- Selects the A operand from the direct or cascade input, then delays it through a configurable-depth pipeline.
- Delays D through its own pipeline, forms the selectable pre-add/sub result, and optionally registers it.
- Drives the multiplier operand, the A concatenation output and the cascade output, with a valid token tracking data latency.

Parameters:
- A_WIDTH, 30, width of A/ACIN/AMUX/ACOUT.
- M_WIDTH, 25, width of D, pre-adder and A_MULT; must be ≤ A_WIDTH.
- A_DEPTH, 2, A pipeline stages (0..4).
- D_DEPTH, 1, D pipeline stages (0..4).
- AD_DEPTH, 1, pre-adder output register stages (0 or 1).
- USE_DPORT, 1, 1 = pre-adder path to A_MULT; 0 = A path only, D ignored.
- INMODE_REG, 1, 1 = INMODE registered once; 0 = combinational.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ce  in  1  pipeline advance; all registers hold when low.
- a_input_sel  in  1  1 = A, 0 = ACIN.
- A  in  A_WIDTH  direct A operand, signed.
- ACIN  in  A_WIDTH  cascade A operand, signed.
- D  in  M_WIDTH  D operand, signed.
- IN_MODE  in  4  [0] first-stage A tap, [1] zero A, [2] enable D, [3] subtract.
- in_valid  in  1  token accompanying A/D.
- AMUX  out  A_WIDTH  last A stage; upper bits for concatenation.
- ACOUT  out  A_WIDTH  cascade output = AMUX.
- A_MULT  out  M_WIDTH  multiplier operand.
- out_valid  out  1  token aligned to A_MULT.
- preadd_ovf  out  1  pre-adder overflow flag; present only with the optional feature.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all A/D/AD/INMODE/valid registers clear to 0. AMUX, ACOUT, A_MULT, out_valid and preadd_ovf are 0 after the reset edge; combinational bypasses reflect inputs.
- rst has priority over ce. Reset mid-stream discards all in-flight tokens.
- A path:
  - a_sel = a_input_sel ? A : ACIN.
  - On each ce edge, stage0 <= a_sel and stage[i] <= stage[i-1].
  - AMUX = stage[A_DEPTH-1]; with A_DEPTH=0, AMUX = a_sel.
- A tap for the pre-adder:
  - IN_MODE[0]=1 and A_DEPTH≥2 selects stage0; otherwise the tap is AMUX. IN_MODE[0] is ignored when A_DEPTH<2.
  - The tap is truncated to the low M_WIDTH bits.
  - a_pre = IN_MODE[1] ? 0 : tap.
- D path: D_DEPTH-stage shift on ce; d_pre = IN_MODE[2] ? d_last : 0.
- Pre-adder:
  - sum = IN_MODE[3] ? d_pre − a_pre : d_pre + a_pre.
  - Computed at M_WIDTH+1 bits; the result is the low M_WIDTH bits (two's-complement wrap).
- AD register: with AD_DEPTH=1, the register loads sum on ce.
- A_MULT:
  - USE_DPORT=1: A_MULT = AD output (or sum when AD_DEPTH=0).
  - USE_DPORT=0: A_MULT = a_pre; D and AD logic are absent and the D port is unused.
- INMODE:
  - INMODE_REG=1: IN_MODE is captured on ce, and the registered copy drives all muxes.
  - INMODE_REG=0: IN_MODE drives the muxes directly.
- Latency:
  - L = A_DEPTH + (USE_DPORT ? AD_DEPTH : 0), measured with the A tap = AMUX.
  - out_valid is in_valid delayed by L ce-qualified edges; with L=0, out_valid = in_valid.
  - The D pipeline is not valid-tracked. The integrator matches D_DEPTH to A_DEPTH.
- Stall: with ce low, every register, including the valid pipe, holds its value. Outputs stay stable except combinational bypasses.

Optional Feature:
- Macro PREADD_SAT_EN.
- Defined:
  - Pre-adder saturates to +2^(M_WIDTH−1)−1 or −2^(M_WIDTH−1) when the M_WIDTH+1-bit sum exceeds range.
  - preadd_ovf is asserted, aligned with A_MULT (registered alongside AD when AD_DEPTH=1).
- Undefined: wrap arithmetic; the preadd_ovf port is removed.

Decomposition:
- Package dsp_pkg holds:
  - INMODE bit-index constants (IM_A1_SEL=0, IM_A_ZERO=1, IM_D_EN=2, IM_SUB=3);
  - the saturation-limit functions for M_WIDTH;
  - the latency function L.
- Sub-module: delay_line_ce (WIDTH, DEPTH, ce, rst), instantiated for the A pipe, D pipe and valid pipe; DEPTH 0 is a wire.

Test Plan:
1. Defaults, A=5, D=7, IN_MODE=4'b0100, in_valid pulse -> A_MULT=12 and out_valid=1 exactly 3 edges later; AMUX=5 after 2 edges.
2. IN_MODE=4'b1100, D=3, A=10 -> A_MULT=−7 (25'h1FFFFF9). IN_MODE=4'b0110 -> A_MULT=3 (A zeroed).
3. a_input_sel=0, ACIN=30'h3FFFFFFF, A=0 -> AMUX=ACOUT=−1 after 2 edges; A_MULT = low 25 bits = −1 with IN_MODE=0.
4. ce held low 4 cycles mid-stream with tokens in flight -> all outputs frozen; resuming ce delivers tokens in order, none lost or duplicated.
5. rst asserted with valid tokens in flight -> next cycle out_valid=0, A_MULT=0, AMUX=0; cascade tokens after release emerge with latency L.
6. With PREADD_SAT_EN, D=2^24−1, A=1, add -> A_MULT=2^24−1 and preadd_ovf=1. Without the macro, A_MULT=−2^24 (wrap).
